// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants and helpers for the round-robin stream demux
//
// Purpose: routing-mode encodings and the round-robin pointer step function.
// Ports:   none (package).

package stream_demux_pkg;

  localparam logic MODE_SEL = 1'b0;  // channel chosen by in_sel
  localparam logic MODE_RR  = 1'b1;  // channel chosen by the rotating pointer

  // Next round-robin pointer: increments and wraps at nch-1, so a
  // non-power-of-two channel count never points at a missing channel.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nch);
    return (ptr == nch - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry valid/data holding register for a single demux lane
//
// Purpose: holds at most one beat for one consumer lane.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   load       in   capture load_data this edge (only asserted while free)
//   load_data  in   DW-bit payload to capture
//   out_ready  in   consumer accepts the held beat
//   out_valid  out  lane holds a beat
//   out_data   out  held payload, all-zero whenever out_valid is 0
//   free       out  slot can take a beat this cycle (empty or draining)

module demux_slot #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          free
);

  // A draining slot counts as free so it can be refilled on the same edge.
  assign free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      // A refill on the draining edge wins over the drain.
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      // Lane data is zeroed whenever it is not valid.
      out_valid <= 1'b0;
      out_data  <= '0;
    end
  end

endmodule

// File: rtl/stream_demux_rr.sv
// rtl/stream_demux_rr.sv - registered 1-to-NCH stream demux, select-directed or round-robin
//
// Purpose: routes each accepted input beat into one of NCH one-entry lane
//          registers, chosen by in_sel (mode 0) or a rotating pointer (mode 1).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   mode       in   0 = use in_sel, 1 = round-robin
//   in_valid   in   producer has a beat
//   in_ready   out  beat accepted this cycle (combinational from out_ready/mode/in_sel)
//   in_data    in   DW-bit payload
//   in_sel     in   target lane in mode 0
//   out_valid  out  per-lane valid, NCH bits
//   out_ready  in   per-lane consumer ready, NCH bits
//   out_data   out  lane k at bits [k*DW +: DW]
//   err_sel    out  one-cycle pulse after an out-of-range in_sel beat was dropped

module stream_demux_rr
  import stream_demux_pkg::*;
#(
  parameter  int DW  = 4,
  parameter  int NCH = 8,
  localparam int SW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic              err_sel
);

  logic [SW-1:0]  rr_ptr;
  logic [SW-1:0]  tgt;
  logic           tgt_ok;
  logic           tgt_free;
  logic           accept;
  logic           drop;
  logic [NCH-1:0] slot_free;
  logic [NCH-1:0] load;

  assign tgt    = (mode == MODE_RR) ? rr_ptr : in_sel;
  // Only reachable as false for non-power-of-two NCH in select mode.
  assign tgt_ok = (32'(tgt) < NCH);

  always_comb begin
    tgt_free = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (tgt == SW'(k)) tgt_free = slot_free[k];
    end
  end

  // Out-of-range selects are always accepted so a bad in_sel cannot
  // wedge the producer; the beat is dropped and flagged on err_sel.
  always_comb begin
    if (rst)         in_ready = 1'b0;
    else if (tgt_ok) in_ready = tgt_free;
    else             in_ready = (mode == MODE_SEL);
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !tgt_ok;

  always_comb begin
    load = '0;
    for (int k = 0; k < NCH; k++) begin
      load[k] = accept && (tgt == SW'(k));
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*DW +: DW]),
      .free      (slot_free[k])
    );
  end

  // The pointer holds through select mode and mode changes; strict order,
  // so a busy target stalls the input rather than being skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      err_sel <= 1'b0;
    end else begin
      err_sel <= drop;
      if (accept && (mode == MODE_RR)) begin
        rr_ptr <= SW'(rr_next(32'(rr_ptr), NCH));
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_rr.sv
// tb/tb_stream_demux_rr.sv - scoreboard testbench for stream_demux_rr

module tb_stream_demux_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [2:0]  in_sel;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [31:0] out_data;
  logic        err_sel;

  logic        rst_b;
  logic        mode_b;
  logic        in_valid_b;
  logic        in_ready_b;
  logic [3:0]  in_data_b;
  logic [2:0]  in_sel_b;
  logic [5:0]  out_valid_b;
  logic [5:0]  out_ready_b;
  logic [23:0] out_data_b;
  logic        err_sel_b;

  int n_checks = 0;
  int n_errors = 0;
  int model_rr = 0;
  logic [3:0] exp_q[8][$];

  always #5 clk = ~clk;

  stream_demux_rr #(.DW(4), .NCH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err_sel(err_sel)
  );

  stream_demux_rr #(.DW(4), .NCH(6)) dut6 (
    .clk(clk), .rst(rst_b), .mode(mode_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_sel(in_sel_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .err_sel(err_sel_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: lanes drained at the coming edge are compared with the
  // scoreboard; idle lanes must read zero.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        if (!out_valid[k]) begin
          check("lane_zero", {28'b0, out_data[k*4 +: 4]}, 32'h0);
        end else if (out_ready[k]) begin
          check("sb_pop_avail", {31'b0, exp_q[k].size() != 0}, 32'h1);
          if (exp_q[k].size() != 0) begin
            check("lane_data", {28'b0, out_data[k*4 +: 4]}, {28'b0, exp_q[k].pop_front()});
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] d, input logic [2:0] s, input logic m);
    int tgt;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    mode     = m;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        tgt = m ? model_rr : int'(s);
        exp_q[tgt].push_back(d);
        if (m) model_rr = (model_rr == 7) ? 0 : model_rr + 1;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_accepted", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
    rst_b = 1'b1; mode_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; in_sel_b = '0; out_ready_b = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'h0);
    check("rst_out_valid", {24'b0, out_valid}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_err_sel", {31'b0, err_sel}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; rst_b = 1'b0;

    // Basic route and back-pressure on lane 3
    send(4'hA, 3'd3, 1'b0);
    @(negedge clk);
    check("route_valid", {24'b0, out_valid}, 32'h08);
    check("route_data", out_data, 32'h0000A000);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 4'h5; in_sel = 3'd3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'h0);
      @(posedge clk); #1;
    end
    out_ready[3] = 1'b1;
    @(negedge clk);
    check("refill_in_ready", {31'b0, in_ready}, 32'h1);
    if (in_ready) exp_q[3].push_back(4'h5);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 8'hFF;
    @(posedge clk); #1;

    // Full throughput into lane 5
    in_valid = 1'b1; in_sel = 3'd5; mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_data = 4'(i);
      @(negedge clk);
      check("tp_in_ready", {31'b0, in_ready}, 32'h1);
      if (in_ready) exp_q[5].push_back(4'(i));
      if (i > 0) check("tp_valid5", {31'b0, out_valid[5]}, 32'h1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Round-robin, 10 beats, pointer wraps 7 -> 0
    in_valid = 1'b1; mode = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 4'(i);
      @(negedge clk);
      check("rr_in_ready", {31'b0, in_ready}, 32'h1);
      if (in_ready) begin
        exp_q[model_rr].push_back(4'(i));
        model_rr = (model_rr == 7) ? 0 : model_rr + 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Strict round-robin stall: pointer at 2, lane 2 blocked
    out_ready = 8'hFB;
    send(4'hB, 3'd2, 1'b0);
    in_valid = 1'b1; mode = 1'b1; in_data = 4'hC;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'h0);
      check("stall_valid", {24'b0, out_valid}, 32'h04);
      @(posedge clk); #1;
    end
    out_ready = 8'hFF;
    @(negedge clk);
    check("unstall_in_ready", {31'b0, in_ready}, 32'h1);
    if (in_ready) begin
      exp_q[model_rr].push_back(4'hC);
      model_rr = (model_rr == 7) ? 0 : model_rr + 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("unstall_lane2", {28'b0, out_data[11:8]}, 32'hC);
    @(posedge clk); #1;
    out_ready = 8'h00;
    send(4'hD, 3'd0, 1'b1);
    @(negedge clk);
    check("rr_next_ch3", {24'b0, out_valid}, 32'h08);
    @(posedge clk); #1;

    // Reset mid-operation
    send(4'h1, 3'd0, 1'b0);
    send(4'h2, 3'd4, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", {24'b0, out_valid}, 32'h19);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) exp_q[k].delete();
    model_rr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {24'b0, out_valid}, 32'h0);
    check("mid_rst_data", out_data, 32'h0);
    @(posedge clk); #1;
    send(4'h7, 3'd5, 1'b1);
    @(negedge clk);
    check("post_rst_rr0", {24'b0, out_valid}, 32'h01);
    check("post_rst_lane0", {28'b0, out_data[3:0]}, 32'h7);
    @(posedge clk); #1;
    out_ready = 8'hFF;
    repeat (3) @(posedge clk);
    #1;

    // Invalid select on the 6-channel instance
    in_valid_b = 1'b1; in_sel_b = 3'd7; in_data_b = 4'h9;
    @(negedge clk);
    check("inv_in_ready", {31'b0, in_ready_b}, 32'h1);
    check("inv_err_before", {31'b0, err_sel_b}, 32'h0);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    @(negedge clk);
    check("inv_err_pulse", {31'b0, err_sel_b}, 32'h1);
    check("inv_no_valid", {26'b0, out_valid_b}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("inv_err_clear", {31'b0, err_sel_b}, 32'h0);
    @(posedge clk); #1;
    in_valid_b = 1'b1; in_sel_b = 3'd5; in_data_b = 4'h6;
    @(negedge clk);
    check("b_in_ready", {31'b0, in_ready_b}, 32'h1);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    @(negedge clk);
    check("b_valid5", {26'b0, out_valid_b}, 32'h20);
    check("b_data5", {8'b0, out_data_b}, 32'h600000);
    check("b_no_err", {31'b0, err_sel_b}, 32'h0);

    @(posedge clk); #1;
    check("sb_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()
          + exp_q[4].size() + exp_q[5].size() + exp_q[6].size() + exp_q[7].size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
